md_ctrl: RTL and testbench

//  Multiply/divide controller for the 5-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU
//  and MTHI/MTLO from the E stage. Sequences a fixed-latency busy window, then commits to
//  HI/LO. Raises the decode-stage stall for any MD-class instruction that finds the unit occupied.

---
 rtl/md_ctrl_pkg.sv | 52 +++++
 rtl/md_core.sv | 50 +++++
 rtl/md_ctrl.sv | 106 ++++++++++
 tb/tb_md_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, op classifiers.
// Latency: n/a (definitions only).
// Backpressure: n/a. Build option MD_MADD_EN enables the MADD/MADDU/MSUB/MSUBU op codes.
package md_ctrl_pkg;

    localparam int WIDTH_MD_OP = 4;

    localparam logic [WIDTH_MD_OP-1:0] MD_OP_NONE  = 4'd0;
    localparam logic [WIDTH_MD_OP-1:0] MD_OP_MULT  = 4'd1;
    localparam logic [WIDTH_MD_OP-1:0] MD_OP_MULTU = 4'd2;
    localparam logic [WIDTH_MD_OP-1:0] MD_OP_DIV   = 4'd3;
    localparam logic [WIDTH_MD_OP-1:0] MD_OP_DIVU  = 4'd4;
    localparam logic [WIDTH_MD_OP-1:0] MD_OP_MTHI  = 4'd5;
    localparam logic [WIDTH_MD_OP-1:0] MD_OP_MTLO  = 4'd6;
    localparam logic [WIDTH_MD_OP-1:0] MD_OP_MADD  = 4'd7;
    localparam logic [WIDTH_MD_OP-1:0] MD_OP_MADDU = 4'd8;
    localparam logic [WIDTH_MD_OP-1:0] MD_OP_MSUB  = 4'd9;
    localparam logic [WIDTH_MD_OP-1:0] MD_OP_MSUBU = 4'd10;

`ifdef MD_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    typedef enum logic { MD_S_IDLE, MD_S_BUSY } md_state_e;

    // How the pending product combines with {hi,lo} at commit.
    typedef enum logic [1:0] { ACC_NONE, ACC_ADD, ACC_SUB } md_acc_e;

    function automatic logic is_div(input logic [WIDTH_MD_OP-1:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

    // Multiply-accumulate ops only exist when the build option is on.
    function automatic logic is_mad(input logic [WIDTH_MD_OP-1:0] op);
        return MADD_EN && ((op == MD_OP_MADD) || (op == MD_OP_MADDU) ||
                           (op == MD_OP_MSUB) || (op == MD_OP_MSUBU));
    endfunction

    // Ops that open a busy window.
    function automatic logic is_busy_op(input logic [WIDTH_MD_OP-1:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_MULTU) || is_div(op) || is_mad(op);
    endfunction

    function automatic md_acc_e acc_mode(input logic [WIDTH_MD_OP-1:0] op);
        if (is_mad(op) && ((op == MD_OP_MADD) || (op == MD_OP_MADDU))) return ACC_ADD;
        if (is_mad(op)) return ACC_SUB;
        return ACC_NONE;
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational 32x32 multiply (64-bit product) and divide (quotient/remainder) datapath.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; result is valid whenever inputs are.
// Ports: op (md op code), a/b (operands) -> result {hi,lo}, div_zero (divide op with b==0).
module md_core
    import md_ctrl_pkg::*;
(
    input  logic [WIDTH_MD_OP-1:0] op,
    input  logic [31:0]            a,
    input  logic [31:0]            b,
    output logic [63:0]            result,
    output logic                   div_zero
);

    logic        signed_op;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        signed_op = (op == MD_OP_MULT) || (op == MD_OP_DIV) ||
                    (op == MD_OP_MADD) || (op == MD_OP_MSUB);
        neg_a     = signed_op & a[31];
        neg_b     = signed_op & b[31];

        // Low 64 bits of the extended product are the exact signed/unsigned product.
        prod      = {{32{neg_a}}, a} * {{32{neg_b}}, b};

        // Divide on magnitudes then fix signs; avoids the 0x80000000/-1 overflow case
        // (magnitude 2^31 is representable unsigned).
        mag_a     = neg_a ? (32'd0 - a) : a;
        mag_b     = neg_b ? (32'd0 - b) : b;
        div_zero  = is_div(op) && (b == 32'd0);
        divisor   = (b == 32'd0) ? 32'd1 : mag_b;
        q_mag     = mag_a / divisor;
        r_mag     = mag_a % divisor;
        quo       = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
        rem       = neg_a ? (32'd0 - r_mag) : r_mag;

        result    = is_div(op) ? {rem, quo} : prod;
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide controller: runs a fixed busy window per MD op, then commits HI/LO.
// Latency: MULT_CYCLES / DIV_CYCLES from start edge to HI/LO valid; MTHI/MTLO one edge.
// Backpressure: md_stall holds D-stage MD ops while busy or while a mult/div is starting.
// Ports: clk, reset (sync, active-high), md_start/md_op/md_a/md_b from E stage, d_is_md
// from decode; md_busy (registered), md_stall (combinational), hi, lo.
// Build option MD_MADD_EN adds MADD/MADDU/MSUB/MSUBU (accumulate into {hi,lo} at commit).
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   md_start,
    input  logic [WIDTH_MD_OP-1:0] md_op,
    input  logic [31:0]            md_a,
    input  logic [31:0]            md_b,
    input  logic                   d_is_md,
    output logic                   md_busy,
    output logic                   md_stall,
    output logic [31:0]            hi,
    output logic [31:0]            lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      pend;
    logic             pend_dz;
    md_acc_e          pend_acc;
    logic [63:0]      core_res;
    logic             core_dz;
    logic [63:0]      commit_val;

    md_core u_core (
        .op       (md_op),
        .a        (md_a),
        .b        (md_b),
        .result   (core_res),
        .div_zero (core_dz)
    );

    // Accumulating ops read {hi,lo} at commit time, not at start.
    always_comb begin
        commit_val = pend;
        case (pend_acc)
            ACC_ADD: commit_val = {hi, lo} + pend;
            ACC_SUB: commit_val = {hi, lo} - pend;
            default: commit_val = pend;
        endcase
    end

    assign md_stall = d_is_md & (md_busy | (md_start & is_busy_op(md_op)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MD_S_IDLE;
            cnt      <= '0;
            md_busy  <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            pend     <= 64'd0;
            pend_dz  <= 1'b0;
            pend_acc <= ACC_NONE;
        end else begin
            case (state)
                MD_S_IDLE: begin
                    if (md_start) begin
                        if (is_busy_op(md_op)) begin
                            pend     <= core_res;
                            pend_dz  <= core_dz;
                            pend_acc <= acc_mode(md_op);
                            cnt      <= is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            state    <= MD_S_BUSY;
                            md_busy  <= 1'b1;
                        end else if (md_op == MD_OP_MTHI) begin
                            hi <= md_a;
                        end else if (md_op == MD_OP_MTLO) begin
                            lo <= md_a;
                        end
                    end
                end
                MD_S_BUSY: begin
                    // Anything started while busy is dropped; the pipeline stall prevents it.
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state   <= MD_S_IDLE;
                        md_busy <= 1'b0;
                        if (!pend_dz) begin
                            hi <= commit_val[63:32];
                            lo <= commit_val[31:0];
                        end
                    end
                end
                default: begin
                    state   <= MD_S_IDLE;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized ops checked against an arithmetic reference model.
// Backpressure: an E-stage start while busy is counted as a protocol violation.
module tb_md_ctrl;
    import md_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_start;
    logic [3:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        d_is_md;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .d_is_md  (d_is_md),
        .md_busy  (md_busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Protocol monitor: an MD op presented while the unit is busy.
    always @(posedge clk) begin
        if (!reset && md_start && md_busy) viol = viol + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Start pulse in one cycle; returns at the negedge after the start edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_start = 1'b1;
        md_op    = op;
        md_a     = a;
        md_b     = b;
        @(negedge clk);
        md_start = 1'b0;
        md_op    = MD_OP_NONE;
    endtask

    // Issue and count busy cycles; bounded so a stuck unit cannot hang the run.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_n);
        issue(op, a, b);
        busy_n = 0;
        while (md_busy === 1'b1 && busy_n < 64) begin
            busy_n++;
            @(negedge clk);
        end
    endtask

    // Reference model: architectural effect of one op on {m_hi,m_lo}, plus busy length.
    task automatic model_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              output int cyc);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          q;
        longint          r;
        logic [63:0]     prod;
        logic [63:0]     acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        cyc = 0;
        case (op)
            MD_OP_MULT:  begin cyc = 5; {m_hi, m_lo} = sa * sb; end
            MD_OP_MULTU: begin cyc = 5; {m_hi, m_lo} = ua * ub; end
            MD_OP_DIV: begin
                cyc = 10;
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            MD_OP_DIVU: begin
                cyc = 10;
                if (b != 0) begin
                    q = longint'(ua / ub); r = longint'(ua % ub);
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            MD_OP_MTHI: m_hi = a;
            MD_OP_MTLO: m_lo = a;
            MD_OP_MADD, MD_OP_MADDU, MD_OP_MSUB, MD_OP_MSUBU: begin
                if (MADD_EN) begin
                    cyc  = 5;
                    prod = ((op == MD_OP_MADD) || (op == MD_OP_MSUB)) ? sa * sb : ua * ub;
                    acc  = {m_hi, m_lo};
                    acc  = ((op == MD_OP_MADD) || (op == MD_OP_MADDU)) ? acc + prod : acc - prod;
                    {m_hi, m_lo} = acc;
                end
            end
            default: cyc = 0;
        endcase
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          ecyc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int          n;
        int          cyc;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        tbl[0] = '{MD_OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        tbl[1] = '{MD_OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[2] = '{MD_OP_DIVU,  32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC, 10};
        tbl[3] = '{MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        tbl[4] = '{MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
        tbl[5] = '{MD_OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
        tbl[6] = '{MD_OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        5};
        tbl[7] = '{MD_OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 5};

        reset = 1'b1; md_start = 1'b0; md_op = MD_OP_NONE; md_a = 0; md_b = 0; d_is_md = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy",  64'(md_busy),  64'd0);
        check("reset_stall", 64'(md_stall), 64'd0);
        check("reset_hi",    64'(hi),       64'd0);
        check("reset_lo",    64'(lo),       64'd0);
        d_is_md = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, n);
            check($sformatf("vec%0d_cycles", i), 64'(n),      64'(tbl[i].ecyc));
            check($sformatf("vec%0d_hi", i),     64'(hi),     64'(tbl[i].ehi));
            check($sformatf("vec%0d_lo", i),     64'(lo),     64'(tbl[i].elo));
        end

        // Stall: asserted in the start cycle and throughout busy, drops with busy.
        @(negedge clk);
        d_is_md = 1'b1; md_start = 1'b1; md_op = MD_OP_MULT; md_a = 32'd2; md_b = 32'd2;
        #1;
        check("stall_start_cycle", 64'(md_stall), 64'd1);
        @(negedge clk);
        md_start = 1'b0; md_op = MD_OP_NONE;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_busy%0d", i), 64'({md_busy, md_stall}), 64'b11);
            @(negedge clk);
        end
        check("stall_after_busy", 64'({md_busy, md_stall}), 64'b00);
        d_is_md = 1'b0;

        // MTHI in idle takes effect at the next edge.
        issue(MD_OP_MTHI, 32'h1234, 32'd0);
        check("mthi_hi", 64'(hi), 64'h1234);
        issue(MD_OP_MTLO, 32'h99, 32'd0);
        check("mtlo_lo", 64'(lo), 64'h99);

        // MTLO while busy is ignored and flagged by the monitor.
        issue(MD_OP_DIV, 32'd100, 32'd7);
        issue(MD_OP_MTLO, 32'h55, 32'd0);
        check("mtlo_busy_lo",   64'(lo),   64'h99);
        check("mtlo_busy_flag", 64'(viol), 64'd1);
        n = 0;
        while (md_busy === 1'b1 && n < 64) begin n++; @(negedge clk); end
        check("div_after_mtlo", 64'({hi, lo}), {32'd2, 32'd14});

        // Divide by zero: full window, HI/LO untouched.
        issue(MD_OP_MTLO, 32'hAA, 32'd0);
        run_op(MD_OP_DIV, 32'd123, 32'd0, n);
        check("divz_cycles", 64'(n), 64'd10);
        check("divz_hilo", 64'({hi, lo}), {32'd2, 32'hAA});

        // Reset during busy: cleared at once, no late commit.
        issue(MD_OP_MTHI, 32'h5, 32'd0);
        issue(MD_OP_DIV, 32'd100, 32'd3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", 64'(md_busy), 64'd0);
        check("rst_mid_hilo", 64'({hi, lo}), 64'd0);
        repeat (15) @(negedge clk);
        check("rst_no_commit", 64'({md_busy, hi, lo}), 64'd0);

        // Multiply-accumulate: acts when enabled, no-op otherwise.
        issue(MD_OP_MTHI, 32'd0, 32'd0);
        issue(MD_OP_MTLO, 32'd1, 32'd0);
        run_op(MD_OP_MADDU, 32'd2, 32'd3, n);
        check("maddu_cycles", 64'(n),  MADD_EN ? 64'd5 : 64'd0);
        check("maddu_lo",     64'(lo), MADD_EN ? 64'd7 : 64'd1);
        check("maddu_hi",     64'(hi), 64'd0);

        // Randomized ops against the reference model.
        m_hi = hi;
        m_lo = lo;
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 10));
            a  = $urandom();
            b  = $urandom();
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = $urandom_range(0, 20); b = $urandom_range(1, 5); end
                2: b = 32'hFFFFFFFF;
                3: a = 32'h80000000;
                default: ;
            endcase
            model_step(op, a, b, cyc);
            run_op(op, a, b, n);
            check($sformatf("rnd%0d_op%0d_cycles", i, op), 64'(n), 64'(cyc));
            check($sformatf("rnd%0d_op%0d_hilo", i, op), {hi, lo}, {m_hi, m_lo});
        end

        check("no_extra_violations", 64'(viol), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
